// File: rtl/q_update_engine.sv
// ----------------------------------------------------------------------------
// q_update_engine
//
// Performs one tabular Q-learning update per request:
//    Q(s,a) <= Q(s,a) + alpha * (r + gamma * max Q(s',*) - Q(s,a))
// alpha = 2^-ALPHA_SHIFT and gamma = 2^-GAMMA_SHIFT, so both are plain shifts.
// The Q-table is external; this block reads Q(s,a), computes the new value,
// clamps it to the unsigned DATA_W range and writes it back.
//
// Ports
//    clk, rst       rising-edge clock, synchronous active-high reset
//    start          update request, only sampled while idle
//    state_idx      state s of the transition
//    action         action a taken (0..8 valid, >8 flags err)
//    reward         signed reward r
//    max_q_next     unsigned max Q(s',*)
//    terminal       1 = s' ends the episode, discount term dropped
//    mem_rd_data    Q(s,a) returned one cycle after mem_rd_en
//    mem_rd_en      Q-table read strobe
//    mem_wr_en      Q-table write strobe
//    mem_addr       {state_idx, action} while an access is in flight, else 0
//    mem_wr_data    updated Q value during the write cycle, else 0
//    busy           high from the cycle after accept until back in idle
//    done           one-cycle completion pulse
//    err            pulses with done when the action was out of range
//    q_new          last value written to the table
// ----------------------------------------------------------------------------
module q_update_engine #(
   parameter int DATA_W      = 18,
   parameter int STATE_W     = 10,
   parameter int ALPHA_SHIFT = 2,
   parameter int GAMMA_SHIFT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] state_idx,
   input  logic [3:0]         action,
   input  logic [DATA_W-1:0]  reward,
   input  logic [DATA_W-1:0]  max_q_next,
   input  logic               terminal,
   input  logic [DATA_W-1:0]  mem_rd_data,
   output logic               mem_rd_en,
   output logic               mem_wr_en,
   output logic [STATE_W+3:0] mem_addr,
   output logic [DATA_W-1:0]  mem_wr_data,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [DATA_W-1:0]  q_new
);

   // Three guard bits cover the full range of reward + discounted max minus
   // q_old without overflow.
   localparam int EXT_W  = 3;
   localparam int CALC_W = DATA_W + EXT_W;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      CALC,
      WRITE,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [STATE_W-1:0] lat_state;
   logic [3:0]         lat_action;
   logic [DATA_W-1:0]  lat_reward;
   logic [DATA_W-1:0]  lat_max_q;
   logic               lat_terminal;
   logic               lat_err;
   logic [DATA_W-1:0]  q_old;
   logic               accept;

   assign accept = (state == IDLE) && start;

   // -------------------------------------------------------------------------
   // Update arithmetic (signed, CALC_W bits)
   // -------------------------------------------------------------------------
   logic signed [CALC_W-1:0] reward_ext;
   logic signed [CALC_W-1:0] disc_term;
   logic signed [CALC_W-1:0] target;
   logic signed [CALC_W-1:0] q_old_ext;
   logic signed [CALC_W-1:0] diff;
   logic signed [CALC_W-1:0] q_calc;
   logic        [DATA_W-1:0] q_clamped;

   assign reward_ext = $signed({{EXT_W{lat_reward[DATA_W-1]}}, lat_reward});
   assign disc_term  = lat_terminal ? '0
                                    : $signed({{EXT_W{1'b0}}, (lat_max_q >> GAMMA_SHIFT)});
   assign target     = reward_ext + disc_term;
   assign q_old_ext  = $signed({{EXT_W{1'b0}}, q_old});
   assign diff       = target - q_old_ext;
   // >>> on a signed operand floors toward negative infinity.
   assign q_calc     = q_old_ext + (diff >>> ALPHA_SHIFT);

   always_comb begin
      if (q_calc[CALC_W-1])
         q_clamped = '0;
      else if (|q_calc[CALC_W-2:DATA_W])
         q_clamped = '1;
      else
         q_clamped = q_calc[DATA_W-1:0];
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // -------------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------------
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would infer a latch.
   always_comb begin
      state_nxt   = state;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;

      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = (action > 4'd8) ? DONE : READ;
         end
         READ: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = {lat_state, lat_action};
            state_nxt = WAIT;
         end
         WAIT: begin
            busy      = 1'b1;
            mem_addr  = {lat_state, lat_action};
            state_nxt = CALC;
         end
         CALC: begin
            busy      = 1'b1;
            mem_addr  = {lat_state, lat_action};
            state_nxt = WRITE;
         end
         WRITE: begin
            busy        = 1'b1;
            mem_wr_en   = 1'b1;
            mem_addr    = {lat_state, lat_action};
            mem_wr_data = q_new;
            state_nxt   = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            err       = lat_err;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Reset also masks the outputs in its own cycle, so a reset landing on
      // WRITE never lets the strobe reach the table.
      if (rst) begin
         state_nxt   = IDLE;
         mem_rd_en   = 1'b0;
         mem_wr_en   = 1'b0;
         mem_addr    = '0;
         mem_wr_data = '0;
         busy        = 1'b0;
         done        = 1'b0;
         err         = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Request latches and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_state    <= '0;
         lat_action   <= '0;
         lat_reward   <= '0;
         lat_max_q    <= '0;
         lat_terminal <= 1'b0;
         lat_err      <= 1'b0;
         q_old        <= '0;
         q_new        <= '0;
      end else begin
         if (accept) begin
            lat_state    <= state_idx;
            lat_action   <= action;
            lat_reward   <= reward;
            lat_max_q    <= max_q_next;
            lat_terminal <= terminal;
            lat_err      <= (action > 4'd8);
         end
         if (state == WAIT)
            q_old <= mem_rd_data;
         if (state == CALC)
            q_new <= q_clamped;
      end
   end

endmodule

// File: tb/tb_q_update_engine.sv
// ----------------------------------------------------------------------------
// tb_q_update_engine
//
// Drives directed and random Q updates into q_update_engine, backs it with a
// Q-table memory model, and compares every cycle of each transaction against
// a reference computed with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_q_update_engine;

   localparam int DATA_W      = 18;
   localparam int STATE_W     = 10;
   localparam int ALPHA_SHIFT = 2;
   localparam int GAMMA_SHIFT = 1;
   localparam int QMAX        = (1 << DATA_W) - 1;
   localparam int DEPTH       = 1 << (STATE_W + 4);

   logic               clk;
   logic               rst;
   logic               start;
   logic [STATE_W-1:0] state_idx;
   logic [3:0]         action;
   logic [DATA_W-1:0]  reward;
   logic [DATA_W-1:0]  max_q_next;
   logic               terminal;
   logic [DATA_W-1:0]  mem_rd_data;
   logic               mem_rd_en;
   logic               mem_wr_en;
   logic [STATE_W+3:0] mem_addr;
   logic [DATA_W-1:0]  mem_wr_data;
   logic               busy;
   logic               done;
   logic               err;
   logic [DATA_W-1:0]  q_new;

   q_update_engine #(
      .DATA_W      (DATA_W),
      .STATE_W     (STATE_W),
      .ALPHA_SHIFT (ALPHA_SHIFT),
      .GAMMA_SHIFT (GAMMA_SHIFT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .state_idx   (state_idx),
      .action      (action),
      .reward      (reward),
      .max_q_next  (max_q_next),
      .terminal    (terminal),
      .mem_rd_data (mem_rd_data),
      .mem_rd_en   (mem_rd_en),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .q_new       (q_new)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Q-table seen by the DUT, plus strobe counters.
   logic [DATA_W-1:0] mem_q [DEPTH];
   int rd_count = 0;
   int wr_count = 0;
   int overlap  = 0;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= mem_q[int'(mem_addr)];
         rd_count    <= rd_count + 1;
      end
      if (mem_wr_en) begin
         mem_q[int'(mem_addr)] <= mem_wr_data;
         wr_count              <= wr_count + 1;
      end
      if (mem_rd_en && mem_wr_en)
         overlap <= overlap + 1;
   end

   // Reference Q-table, updated only by the reference model.
   int ref_mem [DEPTH];
   int exp_q_new = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_update(input int q_old, input int r, input int mq, input bit term);
      int target, diff, div, step, q;
      target = r + (term ? 0 : mq / (1 << GAMMA_SHIFT));
      diff   = target - q_old;
      div    = 1 << ALPHA_SHIFT;
      step   = diff / div;
      if (diff < 0 && step * div != diff)
         step = step - 1;
      q = q_old + step;
      if (q < 0)
         q = 0;
      if (q > QMAX)
         q = QMAX;
      return q;
   endfunction

   task automatic preload(input int addr, input int val);
      mem_q[addr]   = DATA_W'(val);
      ref_mem[addr] = val;
   endtask

   // Called at a negedge in cycle 0 (idle); returns at the negedge of the
   // cycle where the engine is back in idle, so calls chain back-to-back.
   task automatic do_update(input int s, input int a, input int r, input int mq,
                            input bit term, input bit poke);
      int  addr, q_old_e, q_e, wr0, rd0, last;
      bit  valid;
      valid   = (a <= 8);
      addr    = (s << 4) | a;
      wr0     = wr_count;
      rd0     = rd_count;
      q_old_e = ref_mem[addr];
      q_e     = ref_update(q_old_e, r, mq, term);
      last    = valid ? 6 : 2;

      start      = 1'b1;
      state_idx  = STATE_W'(s);
      action     = 4'(a);
      reward     = DATA_W'(r);
      max_q_next = DATA_W'(mq);
      terminal   = term;

      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         start = poke && (c >= 2) && (c <= 5);
         if (c == 1) begin
            state_idx  = STATE_W'($urandom);
            action     = 4'($urandom);
            reward     = DATA_W'($urandom);
            max_q_next = DATA_W'($urandom);
            terminal   = 1'($urandom);
         end
         if (valid) begin
            case (c)
               1: begin
                  check("read_rd_en", mem_rd_en, 1);
                  check("read_wr_en", mem_wr_en, 0);
                  check("read_addr", mem_addr, addr);
                  check("read_busy", busy, 1);
               end
               2: begin
                  check("wait_rd_en", mem_rd_en, 0);
                  check("wait_addr", mem_addr, addr);
                  check("wait_busy", busy, 1);
               end
               3: begin
                  check("calc_strobes", {mem_rd_en, mem_wr_en}, 0);
                  check("calc_addr", mem_addr, addr);
               end
               4: begin
                  check("write_wr_en", mem_wr_en, 1);
                  check("write_rd_en", mem_rd_en, 0);
                  check("write_addr", mem_addr, addr);
                  check("write_data", mem_wr_data, q_e);
               end
               5: begin
                  check("done_pulse", done, 1);
                  check("done_err", err, 0);
                  check("done_addr", mem_addr, 0);
                  check("done_wr_en", mem_wr_en, 0);
                  check("done_q_new", q_new, q_e);
               end
               default: begin
                  check("idle_busy", busy, 0);
                  check("idle_done", done, 0);
               end
            endcase
         end else begin
            case (c)
               1: begin
                  check("inv_done", done, 1);
                  check("inv_err", err, 1);
                  check("inv_rd_en", mem_rd_en, 0);
                  check("inv_addr", mem_addr, 0);
                  check("inv_q_new", q_new, exp_q_new);
               end
               default: begin
                  check("inv_idle_busy", busy, 0);
                  check("inv_idle_done", done, 0);
               end
            endcase
         end
      end

      if (valid) begin
         ref_mem[addr] = q_e;
         exp_q_new     = q_e;
         check("wr_count", wr_count, wr0 + 1);
         check("rd_count", rd_count, rd0 + 1);
      end else begin
         check("inv_wr_count", wr_count, wr0);
         check("inv_rd_count", rd_count, rd0);
      end
   endtask

   // Starts an update and asserts reset while the engine sits in cycle cyc.
   task automatic abort_at(input int cyc, input string tag);
      int wr0;
      wr0        = wr_count;
      start      = 1'b1;
      state_idx  = STATE_W'(3);
      action     = 4'd2;
      reward     = DATA_W'(500);
      max_q_next = DATA_W'(900);
      terminal   = 1'b0;
      for (int c = 1; c <= cyc; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      check({tag, "_same_wr_en"}, mem_wr_en, 0);
      check({tag, "_same_rd_en"}, mem_rd_en, 0);
      check({tag, "_same_busy"}, busy, 0);
      @(negedge clk);
      rst       = 1'b0;
      exp_q_new = 0;
      #1;
      check({tag, "_after_outs"},
            {busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data}, 0);
      check({tag, "_after_q_new"}, q_new, 0);
      repeat (6) @(negedge clk);
      check({tag, "_no_write"}, wr_count, wr0);
      check({tag, "_no_done"}, done, 0);
   endtask

   initial begin
      int s, a, r, mq, rb;
      bit term, poke;

      rst        = 1'b1;
      start      = 1'b1;
      state_idx  = '0;
      action     = '0;
      reward     = '0;
      max_q_next = '0;
      terminal   = 1'b0;

      for (int i = 0; i < DEPTH; i++)
         preload(i, int'($urandom_range(0, QMAX)));

      // Reset state, with start held high to prove it is discarded.
      repeat (3) @(negedge clk);
      check("rst_outputs",
            {busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data}, 0);
      check("rst_q_new", q_new, 0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_start_discarded", busy, 0);

      // Directed arithmetic cases.
      preload(83, 100);
      do_update(5, 3, 40, 200, 1'b0, 1'b0);
      check("basic_110", q_new, 110);

      preload(83, 100);
      do_update(5, 3, -60, 500, 1'b1, 1'b0);
      check("neg_diff_60", q_new, 60);

      preload(17, 0);
      do_update(1, 1, -1000, 0, 1'b1, 1'b0);
      check("clamp_low_0", q_new, 0);

      preload(17, QMAX);
      do_update(1, 1, 131071, QMAX, 1'b0, 1'b0);
      check("top_262142", q_new, 262142);

      // Invalid action leaves q_new alone and never touches memory.
      do_update(2, 9, 7, 7, 1'b0, 1'b0);
      check("inv_keeps_q_new", q_new, 262142);

      // start pulsed through cycles 2..5 is ignored.
      do_update(4, 4, 321, 1234, 1'b0, 1'b1);
      @(negedge clk);
      check("poke_not_queued", busy, 0);

      // Reset during WAIT and during WRITE.
      abort_at(2, "rst_wait");
      abort_at(4, "rst_write");

      // Back-to-back updates to one address: the second read must see the
      // first write.
      preload(40, 5000);
      do_update(2, 8, 1000, 3000, 1'b0, 1'b0);
      do_update(2, 8, -200, 8000, 1'b0, 1'b0);
      check("b2b_mem", mem_q[40], ref_mem[40]);

      // Random updates on a small address set so entries get revisited.
      for (int n = 0; n < 60; n++) begin
         s    = int'($urandom_range(0, 3));
         a    = int'($urandom_range(0, 9));
         rb   = int'($urandom_range(0, QMAX));
         r    = (rb >= (1 << (DATA_W - 1))) ? rb - (1 << DATA_W) : rb;
         mq   = int'($urandom_range(0, QMAX));
         term = 1'($urandom);
         poke = ($urandom_range(0, 3) == 0);
         do_update(s, a, r, mq, term, poke);
      end

      @(negedge clk);
      for (int i = 0; i < 8 * 16; i++)
         check("final_table", mem_q[i], ref_mem[i]);
      check("no_rd_wr_overlap", overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
